// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared types and constants for the scope frame sampler
package scope_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } scope_state_e;

  localparam logic [1:0] MODE_LAST     = 2'd0;
  localparam logic [1:0] MODE_MAX      = 2'd1;
  localparam logic [1:0] MODE_MIN      = 2'd2;
  localparam logic [1:0] MODE_LAST_ALT = 2'd3;

  // A zero-length post-trigger window still captures one frame.
  function automatic int post_load(input int pf);
    return (pf < 1) ? 1 : pf;
  endfunction

endpackage

// File: rtl/scope_reduce.sv
// rtl/scope_reduce.sv - one channel's per-frame accumulator (last/max/min)
module scope_reduce
  import scope_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fb,
  input  logic         sample_valid,
  input  logic [1:0]   mode,
  input  logic [W-1:0] sample,
  output logic [W-1:0] acc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (fb) begin
      // Seed for the next frame; a same-cycle sample belongs to the new frame.
      if (sample_valid) begin
        acc <= sample;
      end else begin
        case (mode)
          MODE_MAX: acc <= '0;
          MODE_MIN: acc <= '1;
          default:  acc <= acc;
        endcase
      end
    end else if (sample_valid) begin
      case (mode)
        MODE_MAX: if (sample > acc) acc <= sample;
        MODE_MIN: if (sample < acc) acc <= sample;
        default:  acc <= sample;
      endcase
    end
  end

endmodule

// File: rtl/scope_frame_sampler.sv
// rtl/scope_frame_sampler.sv - per-frame ADC reduction with armed trigger and freeze
module scope_frame_sampler
  import scope_pkg::*;
#(
  parameter int POST_FRAMES = 320,
  parameter int W           = SAMPLE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vsync,
  input  logic         sample_valid,
  input  logic [W-1:0] ad_a0_in,
  input  logic [W-1:0] ad_a1_in,
  input  logic [W-1:0] ad_b0_in,
  input  logic [W-1:0] ad_b1_in,
  input  logic [1:0]   mode,
  input  logic [1:0]   trig_sel,
  input  logic [W-1:0] trig_level,
  input  logic         trig_arm,
  input  logic         trig_stop,
  output logic [W-1:0] ad_a0,
  output logic [W-1:0] ad_a1,
  output logic [W-1:0] ad_b0,
  output logic [W-1:0] ad_b1,
  output logic         frame_stb,
  output logic         armed,
  output logic         frozen
);

  localparam logic [1:0] S_FREE   = FREE;
  localparam logic [1:0] S_ARMED  = ARMED;
  localparam logic [1:0] S_POST   = POST;
  localparam logic [1:0] S_FROZEN = FROZEN;

  localparam int POST_LOAD = post_load(POST_FRAMES);
  localparam int CW        = $clog2(POST_LOAD + 1);
  localparam logic [CW-1:0] POST_INIT = CW'(POST_LOAD);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [1:0]    state;
  logic [CW-1:0] post_cnt;
  logic          vsync_d1;
  logic          fb;
  logic          upd;
  logic          frame_any;

  logic [W-1:0]  smp [4];
  logic [W-1:0]  acc [4];

  logic [1:0]    sel_d;
  logic [W-1:0]  prev_sel;
  logic          prev_ok;
  logic          sel_changed;
  logic [W-1:0]  cur_sel;
  logic          trig_hit;

  assign smp[0] = ad_a0_in;
  assign smp[1] = ad_a1_in;
  assign smp[2] = ad_b0_in;
  assign smp[3] = ad_b1_in;

  assign fb  = vsync & ~vsync_d1;
  assign upd = fb & (state != S_FROZEN);

  for (genvar i = 0; i < 4; i++) begin : g_ch
    scope_reduce #(.W(W)) u_reduce (
      .clk          (clk),
      .reset        (reset),
      .fb           (fb),
      .sample_valid (sample_valid),
      .mode         (mode),
      .sample       (smp[i]),
      .acc          (acc[i])
    );
  end

  // A frame without valid samples leaves the displayed values untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_d1  <= 1'b0;
      frame_any <= 1'b0;
    end else begin
      vsync_d1 <= vsync;
      if (fb) begin
        frame_any <= sample_valid;
      end else if (sample_valid) begin
        frame_any <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ad_a0     <= '0;
      ad_a1     <= '0;
      ad_b0     <= '0;
      ad_b1     <= '0;
      frame_stb <= 1'b0;
    end else begin
      frame_stb <= upd;
      if (upd && frame_any) begin
        ad_a0 <= acc[0];
        ad_a1 <= acc[1];
        ad_b0 <= acc[2];
        ad_b1 <= acc[3];
      end
    end
  end

  assign cur_sel     = smp[trig_sel];
  assign sel_changed = (trig_sel != sel_d);
  assign trig_hit    = sample_valid & prev_ok & ~sel_changed &
                       (prev_sel < trig_level) & (cur_sel >= trig_level);

  // Switching channels discards history so a stale sample cannot fake an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_d    <= 2'd0;
      prev_sel <= '0;
      prev_ok  <= 1'b0;
    end else begin
      sel_d <= trig_sel;
      if (sample_valid) begin
        prev_sel <= cur_sel;
        prev_ok  <= 1'b1;
      end else if (sel_changed) begin
        prev_sel <= '0;
        prev_ok  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FREE;
      post_cnt <= '0;
    end else if (trig_stop) begin
      state    <= S_FREE;
      post_cnt <= '0;
    end else if (trig_arm) begin
      state    <= S_ARMED;
      post_cnt <= '0;
    end else begin
      case (state)
        S_ARMED: begin
          if (trig_hit) begin
            state    <= S_POST;
            post_cnt <= POST_INIT;
          end
        end
        S_POST: begin
          if (fb) begin
            if (post_cnt == CNT_ONE) begin
              state    <= S_FROZEN;
              post_cnt <= '0;
            end else begin
              post_cnt <= post_cnt - CNT_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign armed  = (state == S_ARMED);
  assign frozen = (state == S_FROZEN);

endmodule

// File: doc/scope_frame_sampler.md
SCOPE_FRAME_SAMPLER -- requirements
Module: scope_frame_sampler

Interface
REQ-001 The block SHALL have parameter POST_FRAMES, default 320, giving the frames captured after a trigger (about half of the 640-column trace).
REQ-002 The block SHALL have parameter W, default 12, giving the sample width.
REQ-003 Port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port vsync, input, 1: display vertical sync; its rising edge marks the frame boundary.
REQ-006 Port sample_valid, input, 1: qualifies the ad_*_in inputs for one cycle.
REQ-007 Ports ad_a0_in, ad_a1_in, ad_b0_in, ad_b1_in, input, W each: raw ADC channel samples.
REQ-008 Port mode, input, 2: per-frame reduction; 0 = last, 1 = max, 2 = min, 3 = last.
REQ-009 Port trig_sel, input, 2: trigger channel; 0 = a0, 1 = a1, 2 = b0, 3 = b1.
REQ-010 Port trig_level, input, W: unsigned trigger threshold.
REQ-011 Port trig_arm, input, 1: one-cycle pulse that arms the trigger.
REQ-012 Port trig_stop, input, 1: one-cycle pulse that returns the block to free-run.
REQ-013 Ports ad_a0, ad_a1, ad_b0, ad_b1, output, W each: per-frame values delivered to the scope display.
REQ-014 Port frame_stb, output, 1: one-cycle pulse, high on the cycle the outputs update.
REQ-015 Port armed, output, 1: high in state ARMED.
REQ-016 Port frozen, output, 1: high in state FROZEN.

Function
REQ-017 Frame boundary: fb = vsync AND NOT vsync_d1, with vsync_d1 registered from vsync.
REQ-018 Reduction: each channel SHALL keep one accumulator, updated on every sample_valid.
- mode 0/3: acc <= sample.
- mode 1: acc <= max(acc, sample).
- mode 2: acc <= min(acc, sample).
- All comparisons are unsigned.
REQ-019 On fb, the block SHALL seed each accumulator for the next frame, then track further samples.
- If sample_valid is high in the same cycle: seed = that sample.
- Otherwise: max mode seeds 0, min mode seeds all-ones, last mode keeps its value.
REQ-020 On fb outside FROZEN, the block SHALL register outputs from the accumulators as they were before the fb update, then pulse frame_stb on the next cycle; output latency is 1 cycle after fb.
REQ-021 If a frame has no valid samples, the outputs SHALL repeat the previous frame's values; frame_stb still pulses.
REQ-022 Trigger detect: trig_hit = (prev_sel < trig_level) AND (cur_sel >= trig_level).
- Evaluated on sample_valid cycles only.
- prev_sel is the last valid sample of the selected channel and updates on every valid sample.
- A change of trig_sel clears the prev_sel history; no hit is possible on the first valid sample after the change.
REQ-023 The state machine SHALL have states FREE, ARMED, POST and FROZEN.
- FREE -> ARMED on trig_arm.
- ARMED -> POST on trig_hit; post_cnt loaded with POST_FRAMES.
- POST: post_cnt decrements on each fb; POST -> FROZEN on the fb that moves post_cnt from 1 to 0. That fb still updates the outputs.
- FROZEN: outputs and frame_stb are held (frame_stb = 0); FROZEN -> ARMED on trig_arm.
- Any state -> FREE on trig_stop.
REQ-024 Simultaneous events:
- trig_stop has priority over trig_arm.
- trig_arm in ARMED or POST restarts ARMED, and post_cnt is cleared.
- A trig_hit and an fb in the same cycle in ARMED: the fb is not counted.
REQ-025 post_cnt SHALL be wide enough to hold POST_FRAMES; POST_FRAMES = 0 SHALL behave as 1.

Reset
REQ-026 Reset SHALL put the state machine in FREE.
REQ-027 Reset SHALL clear to 0: all ad_* outputs, accumulators, prev_sel, post_cnt, vsync_d1, frame_stb, armed and frozen.
REQ-028 Reset asserted mid-frame or in POST SHALL abort the operation; the first fb after reset SHALL produce an update.

Structure
REQ-029 A shared package (scope_pkg) SHALL hold:
- the state enum {FREE, ARMED, POST, FROZEN};
- the mode encodings;
- the default sample width 12.
REQ-030 A sub-module scope_reduce SHALL be instantiated four times, one per channel; it holds one accumulator plus the mode logic.
REQ-031 The outputs SHALL drive the display block's 12-bit channel inputs directly, with no further registering.

Verification
REQ-032 Mode 1: samples 100, 900, 300 in one frame, then fb -> ad_a0 = 900 one cycle later, frame_stb = 1 for exactly 1 cycle.
REQ-033 Mode 2: samples 100, 900, 300 -> ad_a0 = 100; a following frame with no samples -> output stays 100 and frame_stb still pulses.
REQ-034 trig_sel = 2, trig_level = 2048, arm; b0 = 2000 then 2100 -> state POST; POST_FRAMES = 3 -> exactly 3 further frame_stb pulses, then frozen = 1 and no pulses on later fb.
REQ-035 b0 = 2048 then 2100 at trig_level = 2048 -> no trigger (requires prev < level); armed remains 1.
REQ-036 trig_arm and trig_stop in the same cycle while FROZEN -> state FREE, frozen = 0, updates resume on the next fb.
REQ-037 Reset pulsed while in POST with post_cnt = 2 -> all outputs 0 and state FREE; the next fb produces an update.
